// File: rtl/sram_fifo_i_pkt_reader.sv
// Requester-side client of the SRAM controller master read port.
// Pulls one length-prefixed packet from fifo_i, one 16-bit word at a time,
// and streams its payload out as bytes (high byte first) with valid/ready.
module sram_fifo_i_pkt_reader #(
  parameter int MAX_PKT_WORDS = 32,
  parameter int LEN_W         = 11,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             fifo_i_empty,
  output logic             master_read,
  input  logic             master_hint,
  input  logic [15:0]      master_data_from_sram,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic [LEN_W-1:0] pkt_len,
  output logic             busy,
  output logic             pkt_done,
  output logic             pkt_error
);

  localparam int WL_W = $clog2(MAX_PKT_WORDS + 1);
  localparam int BL_W = $clog2(2 * MAX_PKT_WORDS + 1);
  localparam int ST_W = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ_HDR,
    CHK_HDR,
    REQ_DATA,
    EMIT_HI,
    EMIT_LO,
    DONE,
    ERR
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     word;
  logic [WL_W-1:0] words_left;
  logic [BL_W-1:0] bytes_left;
  logic [ST_W-1:0] stall_cnt;

  logic [LEN_W:0]  len_ext;
  logic [LEN_W:0]  len_ceil;
  logic            hdr_bad;
  logic            in_req;
  logic            rd_issue;
  logic            rd_done;
  logic            stalling;
  logic            stall_expire;
  logic            byte_take;
  logic            last_byte;

  // Handshake qualifiers and header checks, shared by FSM and datapath.
  always_comb begin
    len_ext      = {1'b0, pkt_len};
    len_ceil     = (len_ext + 1'b1) >> 1;
    hdr_bad      = (pkt_len == '0) ||
                   (len_ext > (LEN_W + 1)'(2 * MAX_PKT_WORDS));
    in_req       = (state == REQ_HDR) || (state == REQ_DATA);
    rd_issue     = in_req && !master_read && !fifo_i_empty;
    rd_done      = master_read && master_hint;
    stalling     = (state == REQ_DATA) && !master_read && fifo_i_empty;
    stall_expire = stalling && (stall_cnt == ST_W'(STALL_TIMEOUT - 1));
    byte_take    = ((state == EMIT_HI) || (state == EMIT_LO)) && byte_ready;
    last_byte    = (bytes_left == BL_W'(1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nxt  = state;
    byte_valid = 1'b0;
    byte_out   = '0;
    busy       = (state != IDLE);
    pkt_done   = 1'b0;
    pkt_error  = 1'b0;
    unique case (state)
      IDLE:     if (start) state_nxt = REQ_HDR;
      REQ_HDR:  if (rd_done) state_nxt = CHK_HDR;
      CHK_HDR:  state_nxt = hdr_bad ? ERR : REQ_DATA;
      REQ_DATA: begin
        if (rd_done)           state_nxt = EMIT_HI;
        else if (stall_expire) state_nxt = ERR;
      end
      EMIT_HI: begin
        byte_valid = 1'b1;
        byte_out   = word[15:8];
        if (byte_ready) state_nxt = last_byte ? DONE : EMIT_LO;
      end
      EMIT_LO: begin
        byte_valid = 1'b1;
        byte_out   = word[7:0];
        if (byte_ready) state_nxt = last_byte ? DONE : REQ_DATA;
      end
      DONE: begin
        pkt_done  = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        pkt_error = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Read request, word capture, length/byte/word counters and stall timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      master_read <= 1'b0;
      word        <= '0;
      pkt_len     <= '0;
      words_left  <= '0;
      bytes_left  <= '0;
      stall_cnt   <= '0;
    end else begin
      // master_read drops on the hint edge so the controller's post-hint
      // cycles never see a second request.
      if (rd_done)       master_read <= 1'b0;
      else if (rd_issue) master_read <= 1'b1;

      if (rd_done) begin
        if (state == REQ_HDR) begin
          pkt_len <= master_data_from_sram[LEN_W-1:0];
        end else begin
          word       <= master_data_from_sram;
          words_left <= words_left - WL_W'(1);
        end
      end

      if (state == CHK_HDR && !hdr_bad) begin
        words_left <= WL_W'(len_ceil);
        bytes_left <= BL_W'(pkt_len);
      end else if (byte_take) begin
        bytes_left <= bytes_left - BL_W'(1);
      end

      if (stalling) stall_cnt <= stall_cnt + ST_W'(1);
      else          stall_cnt <= '0;
    end
  end

endmodule
